// File: rtl/buffer_pkg.sv
// Shared encodings and sizing for the 64-entry byte buffer and its register file.
// No logic here; consumers import op_type and the depth/width constants.
package buffer_pkg;

    localparam int BUFFER_DEPTH = 64;
    localparam int PTR_WIDTH    = 6;
    localparam int OCC_WIDTH    = PTR_WIDTH + 1;

    localparam logic [OCC_WIDTH-1:0] OCC_FULL  = OCC_WIDTH'(BUFFER_DEPTH);
    localparam logic [OCC_WIDTH-1:0] OCC_EMPTY = '0;

    typedef enum logic [1:0] {
        NOP   = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10
    } op_type;

    typedef enum logic {
        LAST_RD = 1'b0,
        LAST_WR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/buffer_ptr_counter.sv
// Wrapping byte-address pointer with synchronous clear (clear beats increment).
// Latency: new value visible one clk after inc/clr; no backpressure of its own.
module buffer_ptr_counter
    import buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [PTR_WIDTH-1:0] ptr
);

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    // Natural width overflow gives the 63 -> 0 wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/buffer_pointer_ctrl.sv
// Arbitrates one byte WRITE or READ per cycle onto a 64x8 register file and tracks pointers/occupancy.
// Latency: op/acks combinational in the request cycle; requesters hold req until ack, full/empty refuse and flag.
module buffer_pointer_ctrl
    import buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 store_req,
    input  logic                 get_req,
    input  logic                 flush,
    output logic [1:0]           op,
    output logic [PTR_WIDTH-1:0] write_pointer,
    output logic [PTR_WIDTH-1:0] read_pointer,
    output logic                 store_ack,
    output logic                 get_ack,
    output logic [OCC_WIDTH-1:0] buffer_occupancy,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    arb_state_t           state_q;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    op_type               op_sel;
    logic                 wr_elig;
    logic                 rd_elig;
    logic                 do_wr;
    logic                 do_rd;

    assign full    = (occ_q == OCC_FULL);
    assign empty   = (occ_q == OCC_EMPTY);
    assign wr_elig = store_req && !full;
    assign rd_elig = get_req && !empty;

    // n_rst gates the grant so nothing is issued while reset is held.
    always_comb begin
        op_sel = NOP;
        if (n_rst && !flush) begin
            if (wr_elig && rd_elig) begin
                op_sel = (state_q == LAST_RD) ? WRITE : READ;
            end else if (wr_elig) begin
                op_sel = WRITE;
            end else if (rd_elig) begin
                op_sel = READ;
            end
        end
    end

    assign do_wr     = (op_sel == WRITE);
    assign do_rd     = (op_sel == READ);
    assign op        = op_sel;
    assign store_ack = do_wr;
    assign get_ack   = do_rd;

    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (flush) begin
            occ_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (do_wr) begin
                occ_d = occ_q + OCC_WIDTH'(1);
            end else if (do_rd) begin
                occ_d = occ_q - OCC_WIDTH'(1);
            end
            // Losing arbitration never flags; only a full/empty refusal does.
            if (store_req && full && !do_wr) begin
                ovf_d = 1'b1;
            end
            if (get_req && empty && !do_rd) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= LAST_RD;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (flush) begin
                state_q <= LAST_RD;
            end else if (do_wr) begin
                state_q <= LAST_WR;
            end else if (do_rd) begin
                state_q <= LAST_RD;
            end
        end
    end

    assign buffer_occupancy = occ_q;
    assign overflow_err     = ovf_q;
    assign underflow_err    = unf_q;

    buffer_ptr_counter u_wr_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (do_wr),
        .clr   (flush),
        .ptr   (write_pointer)
    );

    buffer_ptr_counter u_rd_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (do_rd),
        .clr   (flush),
        .ptr   (read_pointer)
    );

endmodule

// File: tb/tb_buffer_pointer_ctrl.sv
// Directed bench: a reference model pushes expected op/state per driven cycle, popped and checked as the DUT responds.
module tb_buffer_pointer_ctrl;

    logic       clk;
    logic       n_rst;
    logic       store_req;
    logic       get_req;
    logic       flush;
    logic [1:0] op;
    logic [5:0] write_pointer;
    logic [5:0] read_pointer;
    logic       store_ack;
    logic       get_ack;
    logic [6:0] buffer_occupancy;
    logic       full;
    logic       empty;
    logic       overflow_err;
    logic       underflow_err;

    buffer_pointer_ctrl dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .store_req        (store_req),
        .get_req          (get_req),
        .flush            (flush),
        .op               (op),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .store_ack        (store_ack),
        .get_ack          (get_ack),
        .buffer_occupancy (buffer_occupancy),
        .full             (full),
        .empty            (empty),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] E_NOP = 2'b00;
    localparam logic [1:0] E_WR  = 2'b01;
    localparam logic [1:0] E_RD  = 2'b10;

    typedef struct {
        logic [1:0] op;
        int         wp;
        int         rp;
        int         occ;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Reference model state
    int   m_wp, m_rp, m_occ;
    logic m_last_wr, m_ovf, m_unf;
    logic [1:0] last_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wp = 0; m_rp = 0; m_occ = 0;
        m_last_wr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic cycle(input logic s, input logic g, input logic f);
        exp_t e;
        exp_t got;
        logic s_ok, g_ok;
        store_req = s;
        get_req   = g;
        flush     = f;
        s_ok = s && (m_occ < 64);
        g_ok = g && (m_occ > 0);
        if (f)                 e.op = E_NOP;
        else if (s_ok && g_ok) e.op = m_last_wr ? E_RD : E_WR;
        else if (s_ok)         e.op = E_WR;
        else if (g_ok)         e.op = E_RD;
        else                   e.op = E_NOP;
        if (f) begin
            model_reset();
        end else begin
            if (s && m_occ == 64 && e.op != E_WR) m_ovf = 1'b1;
            if (g && m_occ == 0  && e.op != E_RD) m_unf = 1'b1;
            if (e.op == E_WR) begin
                m_wp = (m_wp + 1) % 64; m_occ++; m_last_wr = 1'b1;
            end else if (e.op == E_RD) begin
                m_rp = (m_rp + 1) % 64; m_occ--; m_last_wr = 1'b0;
            end
        end
        e.wp = m_wp; e.rp = m_rp; e.occ = m_occ; e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);

        @(negedge clk);
        got = sb.pop_front();
        last_op = op;
        chk("op", 32'(op), 32'(got.op));
        chk("store_ack", 32'(store_ack), 32'(got.op == E_WR));
        chk("get_ack", 32'(get_ack), 32'(got.op == E_RD));

        @(posedge clk);
        #1;
        chk("write_pointer", 32'(write_pointer), 32'(got.wp));
        chk("read_pointer", 32'(read_pointer), 32'(got.rp));
        chk("occupancy", 32'(buffer_occupancy), 32'(got.occ));
        chk("full", 32'(full), 32'(got.occ == 64));
        chk("empty", 32'(empty), 32'(got.occ == 0));
        chk("overflow_err", 32'(overflow_err), 32'(got.ovf));
        chk("underflow_err", 32'(underflow_err), 32'(got.unf));
        store_req = 1'b0;
        get_req   = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wp"}, 32'(write_pointer), 32'd0);
        chk({tag, "_rp"}, 32'(read_pointer), 32'd0);
        chk({tag, "_occ"}, 32'(buffer_occupancy), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_err), 32'd0);
        chk({tag, "_unf"}, 32'(underflow_err), 32'd0);
        chk({tag, "_op"}, 32'(op), 32'(E_NOP));
        chk({tag, "_sack"}, 32'(store_ack), 32'd0);
        chk({tag, "_gack"}, 32'(get_ack), 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        store_req = 1'b0;
        get_req = 1'b0;
        flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        n_rst = 1'b1;

        // Write three, read three
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        chk("wr3_wp", 32'(write_pointer), 32'd3);
        chk("wr3_occ", 32'(buffer_occupancy), 32'd3);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        chk("rd3_rp", 32'(read_pointer), 32'd3);
        chk("rd3_empty", 32'(empty), 32'd1);

        // Underflow, cleared by flush
        cycle(1'b0, 1'b1, 1'b0);
        chk("unf_op", 32'(last_op), 32'(E_NOP));
        chk("unf_set", 32'(underflow_err), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("unf_cleared", 32'(underflow_err), 32'd0);

        // Fill to 64 with wrap, then refuse the 65th
        repeat (64) cycle(1'b1, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_wp_wrap", 32'(write_pointer), 32'd0);
        chk("fill_ptrs_eq", 32'(write_pointer == read_pointer), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("ovf_op", 32'(last_op), 32'(E_NOP));
        chk("ovf_set", 32'(overflow_err), 32'd1);
        // Full with both requests: read is the only eligible grant
        cycle(1'b1, 1'b1, 1'b0);
        chk("full_both_op", 32'(last_op), 32'(E_RD));
        cycle(1'b0, 1'b0, 1'b1);

        // Fairness from occupancy 5 with FSM in LAST_RD
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("fair0", 32'(last_op), 32'(E_WR));
        chk("fair0_occ", 32'(buffer_occupancy), 32'd6);
        cycle(1'b1, 1'b1, 1'b0);
        chk("fair1", 32'(last_op), 32'(E_RD));
        chk("fair1_occ", 32'(buffer_occupancy), 32'd5);
        cycle(1'b1, 1'b1, 1'b0);
        chk("fair2", 32'(last_op), 32'(E_WR));
        cycle(1'b1, 1'b1, 1'b0);
        chk("fair3", 32'(last_op), 32'(E_RD));
        chk("fair3_occ", 32'(buffer_occupancy), 32'd5);
        chk("fair_noerr", 32'({overflow_err, underflow_err}), 32'd0);

        // Flush priority at occupancy 10
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        chk("pre_flush_occ", 32'(buffer_occupancy), 32'd10);
        cycle(1'b1, 1'b1, 1'b1);
        chk("flush_op", 32'(last_op), 32'(E_NOP));
        chk("flush_wp", 32'(write_pointer), 32'd0);
        chk("flush_rp", 32'(read_pointer), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);

        // Mid-operation reset after 7 writes, with a store pending
        repeat (7) cycle(1'b1, 1'b0, 1'b0);
        chk("pre_rst_wp", 32'(write_pointer), 32'd7);
        store_req = 1'b1;
        #1;
        n_rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        store_req = 1'b0;
        #1;
        n_rst = 1'b1;
        model_reset();

        // Resumes on the next edge
        cycle(1'b1, 1'b0, 1'b0);
        chk("resume_wp", 32'(write_pointer), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
